// File: rtl/wb_hc165_if.sv
// Wishbone request/response bundle for the 74HC165 reader.
// The master drives the cycle and strobe; the reader returns the byte, the acknowledge and the busy flag.
interface wb_hc165_if;
    logic       i_wb_cyc;
    logic       i_wb_stb;
    logic [7:0] o_wb_data;
    logic       o_wb_ack;
    logic       o_wb_stall;

    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        input  o_wb_data,
        input  o_wb_ack,
        input  o_wb_stall
    );

    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        output o_wb_data,
        output o_wb_ack,
        output o_wb_stall
    );
endinterface

// File: rtl/wb_hc165.sv
// Wishbone-triggered reader for a 74HC165 parallel-in/serial-out shift register.
// One accepted strobe does the following in order:
//   1. pulses PL low to latch the eight inputs;
//   2. lets Q7 settle;
//   3. clocks the eight bits out MSB-first, sampling Q7 at the end of each CP-low phase;
//   4. returns the assembled byte with a one-cycle acknowledge.
// Every FSM state lasts CLK_DIV_RATE clock cycles.
module wb_hc165 #(
    parameter int CLK_DIV_RATE  = 1,
    parameter int CLK_DIV_WIDTH = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    wb_hc165_if.slave     wb,
    output logic          o_shifter_pl_n,
    output logic          o_shifter_cp,
    output logic          o_shifter_ce_n,
    input  logic          i_shifter_q7
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOW    = 3'd3,
        ST_HIGH   = 3'd4
    } state_t;

    localparam logic [CLK_DIV_WIDTH-1:0] TICK_VAL = CLK_DIV_WIDTH'(CLK_DIV_RATE - 1);
    localparam logic [CLK_DIV_WIDTH-1:0] DIV_ZERO = {CLK_DIV_WIDTH{1'b0}};
    localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE  = CLK_DIV_WIDTH'(1);

    state_t                   state_q;
    logic [CLK_DIV_WIDTH-1:0] div_q;
    logic [2:0]               bit_cnt_q;
    logic [7:0]               shreg_q;
    logic [7:0]               rdata_q;
    logic                     ack_q;
    logic                     stall_q;
    logic                     pl_n_q;
    logic                     cp_q;
    logic                     ce_n_q;

    logic                     accept_s;
    logic                     tick_s;

    // Decode request acceptance and the end-of-phase tick.
    always_comb begin
        accept_s = 1'b0;
        tick_s   = 1'b0;
        if (state_q == ST_IDLE) begin
            accept_s = wb.i_wb_cyc && wb.i_wb_stb && !stall_q;
        end else begin
            accept_s = 1'b0;
        end
        if (div_q == TICK_VAL) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Sequencer.
    // Each transition also sets the pin and bus registers that apply to the next state,
    // so every output is glitch-free and lines up with the state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_ZERO;
            bit_cnt_q <= 3'd7;
            shreg_q   <= 8'h00;
            rdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            stall_q   <= 1'b0;
            pl_n_q    <= 1'b1;
            cp_q      <= 1'b0;
            ce_n_q    <= 1'b1;
        end else begin
            // Phase counter runs only while a transfer is in flight.
            if (state_q == ST_IDLE) begin
                div_q <= DIV_ZERO;
            end else if (tick_s) begin
                div_q <= DIV_ZERO;
            end else begin
                div_q <= div_q + DIV_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (accept_s) begin
                        state_q   <= ST_LOAD;
                        shreg_q   <= 8'h00;
                        bit_cnt_q <= 3'd7;
                        stall_q   <= 1'b1;
                        pl_n_q    <= 1'b0;
                        ce_n_q    <= 1'b0;
                        cp_q      <= 1'b0;
                    end else begin
                        // Busy stays up through the ack cycle and drops right after it.
                        stall_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (tick_s) begin
                        state_q <= ST_SETTLE;
                        pl_n_q  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tick_s) begin
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick_s) begin
                        // Q7 has been stable for a whole phase here, so no synchroniser is needed.
                        shreg_q <= {shreg_q[6:0], i_shifter_q7};
                        cp_q    <= 1'b1;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick_s) begin
                        cp_q <= 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            state_q   <= ST_IDLE;
                            ce_n_q    <= 1'b1;
                            rdata_q   <= shreg_q;
                            ack_q     <= 1'b1;
                            bit_cnt_q <= 3'd7;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            state_q   <= ST_LOW;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= 3'd7;
                    ack_q     <= 1'b0;
                    stall_q   <= 1'b0;
                    pl_n_q    <= 1'b1;
                    cp_q      <= 1'b0;
                    ce_n_q    <= 1'b1;
                end
            endcase
        end
    end

    assign wb.o_wb_data   = rdata_q;
    assign wb.o_wb_ack    = ack_q;
    assign wb.o_wb_stall  = stall_q;
    assign o_shifter_pl_n = pl_n_q;
    assign o_shifter_cp   = cp_q;
    assign o_shifter_ce_n = ce_n_q;

endmodule

// File: tb/tb_wb_hc165.sv
// Self-checking bench for wb_hc165.
// Two readers run side by side, one at R=1 and one at R=4, each wired to a behavioural 74HC165.
// Expected pin, bus and data values come from the cycle formulas of the transfer timeline
// and the byte placed on the 165 inputs.
module tb_wb_hc165;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst4_n;

    wb_hc165_if if1 ();
    wb_hc165_if if4 ();

    logic pl1, cp1, ce1, q71;
    logic pl4, cp4, ce4, q74;

    logic [7:0] par1 = 8'h00;
    logic [7:0] par4 = 8'h00;
    logic [7:0] sr1  = 8'h00;
    logic [7:0] sr4  = 8'h00;
    logic       cpp1 = 1'b0;
    logic       cpp4 = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last4 = 8'h00;

    wb_hc165 #(.CLK_DIV_RATE(1), .CLK_DIV_WIDTH(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst1_n), .wb(if1.slave),
        .o_shifter_pl_n(pl1), .o_shifter_cp(cp1), .o_shifter_ce_n(ce1), .i_shifter_q7(q71)
    );

    wb_hc165 #(.CLK_DIV_RATE(4), .CLK_DIV_WIDTH(2)) dut4 (
        .i_clk(clk), .i_reset_n(rst4_n), .wb(if4.slave),
        .o_shifter_pl_n(pl4), .o_shifter_cp(cp4), .o_shifter_ce_n(ce4), .i_shifter_q7(q74)
    );

    // Behavioural 74HC165 for the R=1 reader.
    // It loads while PL is low and shifts left on a CP rise while CE is low.
    assign q71 = sr1[7];
    always @(posedge clk) begin
        if (!pl1) sr1 <= par1;
        else if (cp1 && !cpp1 && !ce1) sr1 <= {sr1[6:0], 1'b0};
        cpp1 <= cp1;
    end

    // Behavioural 74HC165 for the R=4 reader.
    assign q74 = sr4[7];
    always @(posedge clk) begin
        if (!pl4) sr4 <= par4;
        else if (cp4 && !cpp4 && !ce4) sr4 <= {sr4[6:0], 1'b0};
        cpp4 <= cp4;
    end

    // Expected {pl_n, cp, ce_n, stall, ack, data} at cycle c after an accept at cycle 0.
    function automatic logic [12:0] exp_vec(input int r, input int c,
                                             input logic [7:0] b, input logic [7:0] prev);
        logic pl, cp, ce, st, ak;
        logic [7:0] d;
        pl = !(c >= 1 && c <= r);
        ce = !(c >= 1 && c <= 18 * r);
        st = (c >= 1 && c <= 18 * r + 1);
        ak = (c == 18 * r + 1);
        cp = 1'b0;
        if (c >= 2 * r + 1 && c <= 18 * r) cp = (((c - 2 * r - 1) / r) % 2) == 1;
        d  = (c >= 18 * r + 1) ? b : prev;
        return {pl, cp, ce, st, ak, d};
    endfunction

    // Observed {pl_n, cp, ce_n, stall, ack, data} of the reader running at phase length r.
    function automatic logic [12:0] obs_vec(input int r);
        if (r == 1) return {pl1, cp1, ce1, if1.o_wb_stall, if1.o_wb_ack, if1.o_wb_data};
        else        return {pl4, cp4, ce4, if4.o_wb_stall, if4.o_wb_ack, if4.o_wb_data};
    endfunction

    task automatic drive(input int r, input logic cyc, input logic stb);
        if (r == 1) begin if1.i_wb_cyc = cyc; if1.i_wb_stb = stb; end
        else        begin if4.i_wb_cyc = cyc; if4.i_wb_stb = stb; end
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transfer. Call at a negedge; returns at the negedge of cycle 18R+2.
    // With inject set, extra strobes arrive at cycles 5 and 12 and must be ignored.
    task automatic xfer(input int r, input logic [7:0] b, input bit inject);
        logic [7:0] prev;
        logic [12:0] o;
        int rises;
        int pl_lo;
        logic cp_last;
        rises = 0;
        pl_lo = 0;
        cp_last = 1'b0;
        prev = (r == 1) ? last1 : last4;
        if (r == 1) par1 = b; else par4 = b;
        drive(r, 1'b1, 1'b1);
        for (int c = 1; c <= 18 * r + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs_vec(r);
            check($sformatf("xfer_r%0d_b%02h_c%0d", r, b, c), o, exp_vec(r, c, b, prev));
            if (o[11] && !cp_last) rises++;
            cp_last = o[11];
            if (!o[12]) pl_lo++;
            drive(r, 1'b1, inject && (c == 5 || c == 12));
        end
        drive(r, 1'b0, 1'b0);
        check($sformatf("cp_rises_r%0d", r), 13'(rises), 13'd8);
        check($sformatf("pl_low_cycles_r%0d", r), 13'(pl_lo), 13'(r));
        if (r == 1) last1 = b; else last4 = b;
    endtask

    initial begin
        logic [7:0] rb;
        logic [12:0] o;
        drive(1, 1'b0, 1'b0);
        drive(4, 1'b0, 1'b0);
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_r1", obs_vec(1), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        check("reset_r4", obs_vec(4), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        // Basic read at both phase lengths.
        xfer(1, 8'hA5, 1'b0);
        xfer(4, 8'h3C, 1'b0);

        // Strobes during a busy transfer are ignored.
        xfer(1, 8'h5A, 1'b1);

        // A strobe without cyc draws no response.
        drive(1, 1'b0, 1'b1);
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("nocyc_c%0d", c), obs_vec(1), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, last1});
        end
        drive(1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset applied in cycle 9 of a transfer aborts it.
        rb = 8'($urandom);
        par1 = rb;
        drive(1, 1'b1, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("prereset_c%0d", c), obs_vec(1), exp_vec(1, c, rb, last1));
            drive(1, 1'b1, 1'b0);
        end
        rst1_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_c10", obs_vec(1), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst1_n = 1'b1;
        drive(1, 1'b0, 1'b0);
        last1 = 8'h00;
        for (int c = 11; c < 41; c++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs_vec(1);
            check($sformatf("noack_after_reset_c%0d", c), o, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        end

        // Back-to-back transfers: the second accept lands in cycle 20.
        xfer(1, 8'hFF, 1'b0);
        xfer(1, 8'h00, 1'b0);

        // Edge patterns for MSB-first ordering and bit counting.
        xfer(1, 8'h80, 1'b0);
        xfer(1, 8'h01, 1'b0);
        xfer(4, 8'h80, 1'b0);
        xfer(4, 8'h01, 1'b0);

        // Random bytes.
        for (int i = 0; i < 4; i++) xfer(1, 8'($urandom), 1'b0);
        for (int i = 0; i < 2; i++) xfer(4, 8'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
